load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_extend.sv | 26 ++
 rtl/load_store_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory access sizes, funct3
// size codes, exception causes and FSM states.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        DM_NONE = 2'b00,
        DM_BYTE = 2'b01,
        DM_HALF = 2'b10,
        DM_WORD = 2'b11
    } dm_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE           = 2'b00;
    localparam logic [1:0] CAUSE_LOAD_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_STORE_MISALIGN = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL        = 2'b11;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } lsu_state_e;

    // Access size implied by a funct3 code; DM_NONE marks an illegal code.
    function automatic dm_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = DM_BYTE;
            F3_H, F3_HU: f3_size = DM_HALF;
            F3_W:        f3_size = DM_WORD;
            default:     f3_size = DM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word from an aligned memory word and
// sign- or zero-extends it according to the load's funct3.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension; funct3[2] set means unsigned.
    always_comb begin
        byte_sel = word[8*offset +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (f3_size(funct3))
            DM_BYTE: result = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
            DM_HALF: result = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one request at a time, issues the data
// memory access, aligns/extends load data and flags misaligned or illegal
// requests to the trap logic.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dm_read,
    output logic [1:0]  dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    input  logic        flush
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [4:0]  rd_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        exc_valid_q;
    logic [1:0]  exc_cause_q;
    logic [31:0] exc_addr_q;

    dm_size_e    size;
    logic        take;
    logic        illegal;
    logic        misalign;
    logic        go;
    logic        exc_valid_d;
    logic [1:0]  exc_cause_d;
    logic [31:0] ext_result;

    load_extend u_extend (
        .word   (dm_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (ext_result)
    );

    // Request decode; memory strobes are only raised for a legal aligned
    // access accepted this cycle, and never while reset is asserted.
    always_comb begin
        req_ready   = rst_n && (state_q == ST_IDLE);
        take        = req_valid && req_ready && !flush && (req_load || req_store);
        size        = f3_size(req_funct3);
        illegal     = (req_load && req_store) || (size == DM_NONE)
                      || (req_store && req_funct3[2]);
        misalign    = ((size == DM_HALF) && req_addr[0])
                      || ((size == DM_WORD) && (req_addr[1:0] != 2'b00));
        go          = take && !illegal && !misalign;
        dm_read     = go && req_load;
        dm_write    = (go && req_store) ? size : DM_NONE;
        dm_addr     = req_addr;
        dm_wdata    = req_wdata;
        exc_valid_d = take && (illegal || misalign);
        exc_cause_d = illegal  ? CAUSE_ILLEGAL :
                      req_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
    end

    // Control FSM with registered writeback and exception outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            rd_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= CAUSE_NONE;
            exc_addr_q  <= 32'd0;
        end else begin
            wb_valid_q  <= 1'b0;
            exc_valid_q <= exc_valid_d;
            if (exc_valid_d) begin
                exc_cause_q <= exc_cause_d;
                exc_addr_q  <= req_addr;
            end
            case (state_q)
                ST_IDLE: begin
                    if (dm_read) begin
                        state_q  <= ST_LOAD_WAIT;
                        funct3_q <= req_funct3;
                        offset_q <= req_addr[1:0];
                        rd_q     <= req_rd;
                    end
                end
                ST_LOAD_WAIT: begin
                    state_q <= ST_IDLE;
                    // A flush drops the load; an exception always wins the slot.
                    if (!flush && !exc_valid_d) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= ext_result;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

endmodule
